// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: feeds an internal 1-bit ALU slice one operand bit pair per
// clock, LSB first, with a registered carry, then loads result and flags in one step.
module alu_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             c_out,
    output logic             err
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  r_sh_q, r_sh_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              c_out_q, c_out_d;
    logic              err_q, err_d;

    logic [2:0]        slice_op;
    logic              slice_b;
    logic              slice_r;
    logic              slice_c;
    logic              supported;
    logic [WIDTH-1:0]  r_sh_next;
    logic [WIDTH-1:0]  res_new;

    // 1-bit ALU slice; SLT runs as SUB so the difference bit appears on r.
    always_comb begin
        slice_op = (op_q == 3'b111) ? 3'b110 : op_q;
        slice_b  = b_sh_q[0] ^ slice_op[2];
        slice_r  = 1'b0;
        slice_c  = 1'b0;
        case (slice_op)
            3'b000: slice_r = a_sh_q[0] & b_sh_q[0];
            3'b001: slice_r = a_sh_q[0] | b_sh_q[0];
            3'b010, 3'b110: begin
                slice_r = a_sh_q[0] ^ slice_b ^ carry_q;
                slice_c = (a_sh_q[0] & slice_b) | (carry_q & (a_sh_q[0] ^ slice_b));
            end
            default: begin
                slice_r = 1'b0;
                slice_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        supported = 1'b0;
        case (op_q)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    assign r_sh_next = {slice_r, r_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        c_out_d  = c_out_q;
        err_d    = err_q;
        res_new  = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    cnt_d   = '0;
                    carry_d = op[2];
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = r_sh_next;
                carry_d = slice_c;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    if (!supported) begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        c_out_d  = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        // SLT reports the uncorrected sign of a-b.
                        res_new  = (op_q == 3'b111) ? {{(WIDTH-1){1'b0}}, slice_r} : r_sh_next;
                        result_d = res_new;
                        zero_d   = (res_new == '0);
                        c_out_d  = slice_c;
                        err_d    = 1'b0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            c_out_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            c_out_q  <= c_out_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign zero   = zero_q;
    assign c_out  = c_out_q;
    assign err    = err_q;

endmodule
